// File: rtl/regs_bank.sv
// rtl/regs_bank.sv - parametrised integer register file with bypass, debug port and clear sequencer
//
// Purpose
//   NUM_REGS x DATA_W register file, index 0 hard-wired to zero.
//   Two combinational read ports with write-through bypass from the EX write port.
//   A req/ack debug port gives read/write access when the EX port is not writing.
//   After reset a clear sequencer zeroes registers 1..NUM_REGS-1 and holds init_busy_o
//   high until it is done.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i         EX write port
//   raddr1_i/rdata1_o              read port 1 (combinational)
//   raddr2_i/rdata2_o              read port 2 (combinational)
//   dbg_req_i, dbg_we_i,
//   dbg_addr_i, dbg_wdata_i        debug request, held until dbg_ack_o
//   dbg_ack_o, dbg_rdata_o         one-cycle completion pulse and read data
//   init_busy_o                    clear sequencer running
//   parity_err_o                   per-port parity mismatch
//
// Configuration
//   REGS_PARITY_EN  store an even-parity bit per register and check it on reads;
//                   when undefined parity_err_o is tied to 2'b00.
module regs_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              init_busy_o,
  output logic [1:0]        parity_err_o
);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_DBG_ACK = 2'd2;

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   NUM_REGS_EXT = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX     = ADDR_W'(NUM_REGS-1);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_EXT);
  endfunction

  // A real EX write: enabled, not x0, in range, and not during the clear.
  logic ex_wr;
  assign ex_wr = we_i && (waddr_i != '0) && in_range(waddr_i) && (state_q != ST_INIT);

  logic dbg_ok;
  assign dbg_ok = (dbg_addr_i != '0) && in_range(dbg_addr_i);

  // Read ports
  logic rd1_ok, rd2_ok, byp1, byp2;
  assign rd1_ok = (raddr1_i != '0) && in_range(raddr1_i);
  assign rd2_ok = (raddr2_i != '0) && in_range(raddr2_i);
  assign byp1   = ex_wr && (waddr_i == raddr1_i);
  assign byp2   = ex_wr && (waddr_i == raddr2_i);

  assign rdata1_o = !rd1_ok ? '0 : (byp1 ? wdata_i : mem_q[raddr1_i]);
  assign rdata2_o = !rd2_ok ? '0 : (byp2 ? wdata_i : mem_q[raddr2_i]);

  assign dbg_ack_o   = (state_q == ST_DBG_ACK);
  assign dbg_rdata_o = dbg_rdata_q;
  assign init_busy_o = (state_q == ST_INIT);

  // Control: the clear sequencer, EX port and debug port share one physical
  // write port; the state decides who owns it this cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dbg_rdata_d = dbg_rdata_q;
    mem_we      = 1'b0;
    mem_waddr   = waddr_i;
    mem_wdata   = wdata_i;
    case (state_q)
      ST_INIT: begin
        mem_we    = in_range(cnt_q);
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (cnt_q >= LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (ex_wr) begin
          // EX wins; a debug request simply stays pending.
          mem_we = 1'b1;
        end else if (dbg_req_i) begin
          state_d = ST_DBG_ACK;
          if (dbg_we_i) begin
            mem_we      = dbg_ok;
            mem_waddr   = dbg_addr_i;
            mem_wdata   = dbg_wdata_i;
            dbg_rdata_d = '0;
          end else begin
            dbg_rdata_d = dbg_ok ? mem_q[dbg_addr_i] : '0;
          end
        end
      end
      ST_DBG_ACK: begin
        mem_we  = ex_wr;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= ADDR_W'(1);
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef REGS_PARITY_EN
  logic par_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      par_q[mem_waddr] <= ^mem_wdata;
    end
  end

  // Bypassed data never touched storage, so it is not checked.
  assign parity_err_o[0] = rd1_ok && !byp1 && ((^mem_q[raddr1_i]) != par_q[raddr1_i]);
  assign parity_err_o[1] = rd2_ok && !byp2 && ((^mem_q[raddr2_i]) != par_q[raddr2_i]);
`else
  assign parity_err_o = 2'b00;
`endif

endmodule

// File: tb/tb_regs_bank.sv
// tb/tb_regs_bank.sv - directed self-checking testbench for regs_bank
module tb_regs_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [4:0]  raddr1_i = '0;
  logic [4:0]  raddr2_i = '0;
  logic [31:0] rdata1_o;
  logic [31:0] rdata2_o;
  logic        dbg_req_i = 1'b0;
  logic        dbg_we_i = 1'b0;
  logic [4:0]  dbg_addr_i = '0;
  logic [31:0] dbg_wdata_i = '0;
  logic        dbg_ack_o;
  logic [31:0] dbg_rdata_o;
  logic        init_busy_o;
  logic [1:0]  parity_err_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regs_bank #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .raddr1_i     (raddr1_i),
    .raddr2_i     (raddr2_i),
    .rdata1_o     (rdata1_o),
    .rdata2_o     (rdata2_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_ack_o    (dbg_ack_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .init_busy_o  (init_busy_o),
    .parity_err_o (parity_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_write(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    int acks;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    // Debug write and EX write held through the clear: both must be ignored.
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd6; dbg_wdata_i = 32'h66;
    we_i = 1'b1; waddr_i = 5'd2; wdata_i = 32'hBAD;
    #1;
    tests_run++;
    if (init_busy_o !== 1'b1 || dbg_ack_o !== 1'b0 || dbg_rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b ack=%b drdata=%h want 1 0 0", init_busy_o, dbg_ack_o, dbg_rdata_o);
    end
    n = 0; acks = 0;
    while (init_busy_o === 1'b1 && n < 100) begin
      step();
      n++;
      if (dbg_ack_o === 1'b1) acks++;
    end
    we_i = 1'b0; dbg_req_i = 1'b0;
    tests_run++;
    if (n != 31) begin
      tests_failed++;
      $display("FAIL init_cycles: got %0d want 31", n);
    end
    tests_run++;
    if (acks != 0) begin
      tests_failed++;
      $display("FAIL init_dbg_ignored: got %0d acks want 0", acks);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1_i = 5'(i); raddr2_i = 5'(31 - i);
      #1;
      tests_run++;
      if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL cleared_read[%0d]: got %h/%h want 0/0", i, rdata1_o, rdata2_o);
      end
    end
  endtask

  task automatic test_bypass();
    we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF; raddr1_i = 5'd5; raddr2_i = 5'd6;
    #1;
    tests_run++;
    if (rdata1_o !== 32'hDEADBEEF || rdata2_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got %h/%h want deadbeef/0", rdata1_o, rdata2_o);
    end
    step();
    we_i = 1'b0;
    #1;
    tests_run++;
    if (rdata1_o !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL bypass_stored: got %h want deadbeef", rdata1_o);
    end
  endtask

  task automatic test_no_false_bypass();
    ex_write(5'd7, 32'hAA);
    we_i = 1'b0; waddr_i = 5'd7; wdata_i = 32'h1234; raddr2_i = 5'd7; raddr1_i = 5'd7;
    #1;
    tests_run++;
    if (rdata2_o !== 32'hAA || rdata1_o !== 32'hAA) begin
      tests_failed++;
      $display("FAIL no_false_bypass: got %h/%h want aa/aa", rdata1_o, rdata2_o);
    end
    // Ports are independent: only the matching port bypasses.
    we_i = 1'b1; raddr1_i = 5'd8;
    #1;
    tests_run++;
    if (rdata1_o !== 32'h0 || rdata2_o !== 32'h1234) begin
      tests_failed++;
      $display("FAIL port_independent: got %h/%h want 0/1234", rdata1_o, rdata2_o);
    end
    we_i = 1'b0;
    step();
  endtask

  task automatic test_dbg();
    we_i = 1'b1; waddr_i = 5'd10; wdata_i = 32'h10;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd3; dbg_wdata_i = 32'h55;
    step();
    we_i = 1'b0;
    tests_run++;
    if (dbg_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbg_blocked_by_ex: ack=%b want 0", dbg_ack_o);
    end
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL dbg_write_ack: ack=%b want 1", dbg_ack_o);
    end
    dbg_req_i = 1'b0;
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbg_ack_single: ack=%b want 0", dbg_ack_o);
    end
    raddr1_i = 5'd3; raddr2_i = 5'd10;
    #1;
    tests_run++;
    if (rdata1_o !== 32'h55 || rdata2_o !== 32'h10) begin
      tests_failed++;
      $display("FAIL dbg_write_data: got %h/%h want 55/10", rdata1_o, rdata2_o);
    end
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h55) begin
      tests_failed++;
      $display("FAIL dbg_read: ack=%b data=%h want 1 55", dbg_ack_o, dbg_rdata_o);
    end
    // EX write during the ack cycle must land.
    dbg_req_i = 1'b0;
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'hB;
    step();
    we_i = 1'b0; raddr1_i = 5'd11;
    #1;
    tests_run++;
    if (rdata1_o !== 32'hB || dbg_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ex_in_ack: got %h ack=%b want b 0", rdata1_o, dbg_ack_o);
    end
  endtask

  task automatic test_back_to_back();
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd10;
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h10) begin
      tests_failed++;
      $display("FAIL b2b_first: ack=%b data=%h want 1 10", dbg_ack_o, dbg_rdata_o);
    end
    dbg_addr_i = 5'd3;
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: ack=%b want 0", dbg_ack_o);
    end
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h55) begin
      tests_failed++;
      $display("FAIL b2b_second: ack=%b data=%h want 1 55", dbg_ack_o, dbg_rdata_o);
    end
    dbg_req_i = 1'b0;
    step();
  endtask

  task automatic test_zero();
    we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'hFFFFFFFF; raddr1_i = 5'd0;
    #1;
    tests_run++;
    if (rdata1_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_no_bypass: got %h want 0", rdata1_o);
    end
    step();
    we_i = 1'b0;
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'hFFFFFFFF;
    step();
    dbg_req_i = 1'b0;
    step();
    tests_run++;
    if (rdata1_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL x0_after_writes: got %h want 0", rdata1_o);
    end
    dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd0;
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b1 || dbg_rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL dbg_read_x0: ack=%b data=%h want 1 0", dbg_ack_o, dbg_rdata_o);
    end
    dbg_req_i = 1'b0;
    step();
  endtask

  task automatic test_parity();
    ex_write(5'd4, 32'h3);
    raddr1_i = 5'd4; raddr2_i = 5'd4;
    #1;
    tests_run++;
    if (parity_err_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL parity_clean: got %b want 00", parity_err_o);
    end
`ifdef REGS_PARITY_EN
    dut.mem_q[4][0] = 1'b0;
    raddr2_i = 5'd7;
    #1;
    tests_run++;
    if (parity_err_o !== 2'b01) begin
      tests_failed++;
      $display("FAIL parity_flip: got %b want 01", parity_err_o);
    end
    ex_write(5'd4, 32'h3);
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    int acks;
    ex_write(5'd9, 32'h77);
    raddr1_i = 5'd9;
    #1;
    tests_run++;
    if (rdata1_o !== 32'h77) begin
      tests_failed++;
      $display("FAIL reg9_set: got %h want 77", rdata1_o);
    end
    dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h99;
    step();
    tests_run++;
    if (dbg_ack_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_ack: ack=%b want 1", dbg_ack_o);
    end
    rst = 1'b1; dbg_req_i = 1'b0;
    step();
    rst = 1'b0;
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h1111; raddr1_i = 5'd9;
    #1;
    tests_run++;
    if (dbg_ack_o !== 1'b0 || init_busy_o !== 1'b1 || rdata1_o !== 32'h99) begin
      tests_failed++;
      $display("FAIL mid_reset_state: ack=%b busy=%b rd=%h want 0 1 99", dbg_ack_o, init_busy_o, rdata1_o);
    end
    n = 0; acks = 0;
    while (init_busy_o === 1'b1 && n < 100) begin
      step();
      n++;
      if (dbg_ack_o === 1'b1) acks++;
    end
    we_i = 1'b0;
    #1;
    tests_run++;
    if (n != 31 || acks != 0) begin
      tests_failed++;
      $display("FAIL rerun_clear: cycles=%0d acks=%0d want 31 0", n, acks);
    end
    tests_run++;
    if (rdata1_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reg9_cleared: got %h want 0", rdata1_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bypass();
    test_no_false_bypass();
    test_dbg();
    test_back_to_back();
    test_zero();
    test_parity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
